// File: rtl/bioee_clkmeter.sv
`timescale 1ns / 1ps
// Measures period (rise-to-rise) and high time (rise-to-fall) of a slow clock, in clkin cycles.
// Reports lock when two consecutive periods match; flags a sticky timeout on a stalled input.
module bioee_clkmeter #(
  parameter int unsigned PERIOD_W = 32,
  parameter int unsigned TIMEOUT  = 1048576,
  parameter int unsigned SYNC_STG = 2
) (
  input  logic                i_clkin,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic                i_sigin,
  output logic [PERIOD_W-1:0] o_period,
  output logic [PERIOD_W-1:0] o_high_time,
  output logic                o_period_valid,
  output logic                o_locked,
  output logic                o_timeout
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;

  localparam logic [PERIOD_W-1:0] TIMEOUT_CNT = PERIOD_W'(TIMEOUT);
  localparam logic [PERIOD_W-1:0] CNT_MAX     = '1;
  localparam logic [PERIOD_W-1:0] CNT_ONE     = PERIOD_W'(1);

  logic [SYNC_STG-1:0] r_sync;
  logic                r_sig_d;
  logic [1:0]          r_state;
  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_high;
  logic                r_valid;
  logic                r_locked;
  logic                r_timeout;
  logic                r_have_prev;

  logic                w_sig;
  logic                w_rise;
  logic                w_fall;
  logic                w_hit;
  logic [PERIOD_W-1:0] w_cnt_inc;
  logic [1:0]          w_state_nxt;
  logic [PERIOD_W-1:0] w_cnt_nxt;
  logic [PERIOD_W-1:0] w_period_nxt;
  logic [PERIOD_W-1:0] w_high_nxt;
  logic                w_valid_nxt;
  logic                w_locked_nxt;
  logic                w_timeout_nxt;
  logic                w_have_prev_nxt;

  assign w_sig     = r_sync[SYNC_STG-1];
  assign w_rise    = w_sig & ~r_sig_d;
  assign w_fall    = ~w_sig & r_sig_d;
  assign w_hit     = (r_cnt >= TIMEOUT_CNT);
  // Saturate rather than wrap so a stalled input never aliases to a short period.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_period_nxt    = r_period;
    w_high_nxt      = r_high;
    w_valid_nxt     = 1'b0;
    w_locked_nxt    = r_locked;
    w_timeout_nxt   = r_timeout;
    w_have_prev_nxt = r_have_prev;
    if (!i_enable) begin
      w_state_nxt     = ST_IDLE;
      w_cnt_nxt       = '0;
      w_locked_nxt    = 1'b0;
      w_have_prev_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt     = ST_ARM;
          w_cnt_nxt       = '0;
          w_have_prev_nxt = 1'b0;
        end
        ST_ARM: begin
          if (w_rise) begin
            w_state_nxt   = ST_MEAS;
            w_cnt_nxt     = CNT_ONE;
            w_timeout_nxt = 1'b0;
          end else if (w_hit) begin
            w_cnt_nxt     = '0;
            w_timeout_nxt = 1'b1;
            w_locked_nxt  = 1'b0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        ST_MEAS: begin
          // A rise in the same cycle as the timeout threshold takes precedence.
          if (w_rise) begin
            w_cnt_nxt       = CNT_ONE;
            w_period_nxt    = r_cnt;
            w_valid_nxt     = 1'b1;
            w_locked_nxt    = r_have_prev && (r_cnt == r_period);
            w_have_prev_nxt = 1'b1;
          end else if (w_hit) begin
            w_state_nxt     = ST_ARM;
            w_cnt_nxt       = '0;
            w_timeout_nxt   = 1'b1;
            w_locked_nxt    = 1'b0;
            w_have_prev_nxt = 1'b0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
            if (w_fall) begin
              w_high_nxt = r_cnt;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clkin or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync      <= '0;
      r_sig_d     <= 1'b0;
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_period    <= '0;
      r_high      <= '0;
      r_valid     <= 1'b0;
      r_locked    <= 1'b0;
      r_timeout   <= 1'b0;
      r_have_prev <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STG-2:0], i_sigin};
      r_sig_d     <= w_sig;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_period    <= w_period_nxt;
      r_high      <= w_high_nxt;
      r_valid     <= w_valid_nxt;
      r_locked    <= w_locked_nxt;
      r_timeout   <= w_timeout_nxt;
      r_have_prev <= w_have_prev_nxt;
    end
  end

  assign o_period       = r_period;
  assign o_high_time    = r_high;
  assign o_period_valid = r_valid;
  assign o_locked       = r_locked;
  assign o_timeout      = r_timeout;

endmodule

// File: tb/tb_bioee_clkmeter.sv
`timescale 1ns / 1ps
// Directed bench for bioee_clkmeter: table of divider patterns plus reset, enable,
// timeout and asynchronous-jitter sequences. dut_b uses a short timeout.
module tb_bioee_clkmeter;

  localparam int PW = 16;

  logic clk = 1'b0;
  logic rst_n, enable, sigin;
  logic [PW-1:0] a_period, a_high, b_period, b_high;
  logic a_valid, a_locked, a_timeout, b_valid, b_locked, b_timeout;

  always #5 clk = ~clk;

  bioee_clkmeter #(.PERIOD_W(PW), .TIMEOUT(4096), .SYNC_STG(2)) dut_a (
    .i_clkin(clk), .i_rst_n(rst_n), .i_enable(enable), .i_sigin(sigin),
    .o_period(a_period), .o_high_time(a_high), .o_period_valid(a_valid),
    .o_locked(a_locked), .o_timeout(a_timeout)
  );

  bioee_clkmeter #(.PERIOD_W(PW), .TIMEOUT(64), .SYNC_STG(2)) dut_b (
    .i_clkin(clk), .i_rst_n(rst_n), .i_enable(enable), .i_sigin(sigin),
    .o_period(b_period), .o_high_time(b_high), .o_period_valid(b_valid),
    .o_locked(b_locked), .o_timeout(b_timeout)
  );

  typedef struct {
    int per;
    int hi;
    int lk;
    int cyc;
  } pulse_t;

  typedef struct {
    int hi;
    int lo;
    int reps;
    int exp_period;
    int exp_high;
    int exp_lock_first;
  } row_t;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  pulse_t qa[$];
  pulse_t mon_p;
  int     b_pv_cyc = -1;
  int     b_to_cyc = -1;
  logic   b_to_prev = 1'b0;
  int     tq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (a_valid === 1'b1) begin
      mon_p.per = int'(a_period);
      mon_p.hi  = int'(a_high);
      mon_p.lk  = int'(a_locked);
      mon_p.cyc = cyc;
      qa.push_back(mon_p);
    end
    if (b_valid === 1'b1) b_pv_cyc = cyc;
    if (b_timeout === 1'b1 && b_to_prev !== 1'b1) b_to_cyc = cyc;
    b_to_prev = b_timeout;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic drive(input int hi, input int lo);
    sigin = 1'b1;
    repeat (hi) @(negedge clk);
    sigin = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t rows[5];
    int   k;
    int   rel_cyc;
    int   t;

    rows[0] = '{hi: 5,   lo: 5,   reps: 4, exp_period: 10,   exp_high: 5,   exp_lock_first: 0};
    rows[1] = '{hi: 1,   lo: 1,   reps: 4, exp_period: 2,    exp_high: 1,   exp_lock_first: 0};
    rows[2] = '{hi: 500, lo: 500, reps: 3, exp_period: 1000, exp_high: 500, exp_lock_first: 0};
    rows[3] = '{hi: 3,   lo: 7,   reps: 3, exp_period: 10,   exp_high: 3,   exp_lock_first: 0};
    rows[4] = '{hi: 4,   lo: 6,   reps: 3, exp_period: 10,   exp_high: 4,   exp_lock_first: 1};

    rst_n = 1'b0;
    enable = 1'b0;
    sigin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_period", a_period, 0);
    check("rst_high", a_high, 0);
    check("rst_valid", a_valid, 0);
    check("rst_locked", a_locked, 0);
    check("rst_timeout", a_timeout, 0);
    check("rst_b_period", b_period, 0);
    rst_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    repeat (4) @(negedge clk);

    // Divider patterns, back to back; the final rise closes the last period.
    qa.delete();
    foreach (rows[i]) repeat (rows[i].reps) drive(rows[i].hi, rows[i].lo);
    sigin = 1'b1;
    repeat (5) @(negedge clk);
    sigin = 1'b0;
    repeat (20) @(negedge clk);
    check("tbl_count", qa.size(), 17);
    k = 0;
    foreach (rows[i]) begin
      for (int j = 0; j < rows[i].reps; j++) begin
        if (k < qa.size()) begin
          check($sformatf("tbl_period[%0d]", k), qa[k].per, rows[i].exp_period);
          check($sformatf("tbl_high[%0d]", k), qa[k].hi, rows[i].exp_high);
          check($sformatf("tbl_locked[%0d]", k), qa[k].lk, (j == 0) ? rows[i].exp_lock_first : 1);
          if (j > 0)
            check($sformatf("tbl_spacing[%0d]", k), qa[k].cyc - qa[k-1].cyc, rows[i].exp_period);
        end
        k++;
      end
    end

    // Timeout on dut_b (TIMEOUT=64) after lock.
    repeat (80) @(negedge clk);
    repeat (4) drive(5, 5);
    sigin = 1'b1;
    repeat (5) @(negedge clk);
    sigin = 1'b0;
    check("to_pre_locked", b_locked, 1);
    check("to_pre_period", b_period, 10);
    check("to_pre_timeout", b_timeout, 0);
    b_to_cyc = -1;
    for (int i = 0; i < 100 && b_to_cyc < 0; i++) @(negedge clk);
    check("to_delay", b_to_cyc - b_pv_cyc, 64);
    check("to_flag", b_timeout, 1);
    check("to_locked", b_locked, 0);
    check("to_period_hold", b_period, 10);
    check("to_high_hold", b_high, 5);
    sigin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("to_before_rise", b_timeout, 1);
    @(posedge clk);
    #1;
    check("to_cleared_on_rise", b_timeout, 0);
    @(negedge clk);
    @(negedge clk);
    sigin = 1'b0;
    repeat (5) @(negedge clk);

    // Reset mid-period.
    repeat (3) drive(5, 5);
    sigin = 1'b1;
    repeat (3) @(negedge clk);
    check("rm_pre_locked", a_locked, 1);
    rst_n = 1'b0;
    #1;
    check("rm_period", a_period, 0);
    check("rm_high", a_high, 0);
    check("rm_valid", a_valid, 0);
    check("rm_locked", a_locked, 0);
    check("rm_timeout", a_timeout, 0);
    repeat (2) @(negedge clk);
    sigin = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    qa.delete();
    rel_cyc = cyc;
    repeat (3) drive(5, 5);
    sigin = 1'b1;
    repeat (5) @(negedge clk);
    check("rm_count", qa.size(), 3);
    if (qa.size() >= 3) begin
      check("rm_first_cyc", qa[0].cyc - rel_cyc, 13);
      check("rm_first_period", qa[0].per, 10);
      check("rm_first_high", qa[0].hi, 5);
      check("rm_first_locked", qa[0].lk, 0);
      check("rm_third_locked", qa[2].lk, 1);
    end

    // Enable dropped mid-period, raised mid-period.
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("en_locked_low", a_locked, 0);
    qa.delete();
    sigin = 1'b0;
    repeat (5) @(negedge clk);
    repeat (2) drive(5, 5);
    sigin = 1'b1;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    sigin = 1'b0;
    repeat (5) @(negedge clk);
    check("en_no_pulse", qa.size(), 0);
    check("en_period_hold", a_period, 10);
    check("en_high_hold", a_high, 5);
    repeat (2) drive(5, 5);
    sigin = 1'b1;
    repeat (5) @(negedge clk);
    sigin = 1'b0;
    repeat (3) @(negedge clk);
    check("en_count", qa.size(), 2);
    if (qa.size() >= 2) begin
      check("en_first_period", qa[0].per, 10);
      check("en_first_locked", qa[0].lk, 0);
      check("en_second_locked", qa[1].lk, 1);
    end

    // Asynchronous sigin, ~7.3 clkin cycles per period with +-1 cycle jitter.
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    qa.delete();
    tq.delete();
    @(posedge clk);
    #2.3;
    for (int i = 0; i < 40; i++) begin
      t = 73 + int'($urandom_range(20)) - 10;
      tq.push_back(t);
      sigin = 1'b1;
      #36;
      sigin = 1'b0;
      #(t - 36);
    end
    sigin = 1'b1;
    #36;
    sigin = 1'b0;
    @(negedge clk);
    repeat (10) @(negedge clk);
    check("async_count", qa.size(), 40);
    for (int i = 0; i < 40 && i < qa.size(); i++) begin
      check_range($sformatf("async_period[%0d]", i), qa[i].per, tq[i] / 10, (tq[i] + 9) / 10);
      check_range($sformatf("async_high[%0d]", i), qa[i].hi, 3, 4);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
